param_register_file: RTL and testbench

Parametrised 2-read/1-write register file for the multicycle datapath. Generalises the current 32x24 register file in data width and depth, and adds the following:
- concurrent read and write in the same cycle;
- optional write-to-read bypass;
- optional hardwired-zero register 0;
- a post-reset clearing sweep, so every entry starts at a known zero.

It sits between the instruction decode stage and the ALU operand latches. The `read_valid` and `init_busy` outputs serve the control FSM.

---
 rtl/param_register_file.sv | 164 ++++++++++++++++
 tb/tb_param_register_file.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// param_register_file: 2-read/1-write register file with a post-reset clearing
// sweep, optional same-cycle write-to-read bypass and optional hardwired-zero
// entry 0. Read data is registered (1-cycle latency) and qualified by read_valid.

// One registered read port: picks stale entry / bypassed write data / zero.
module rf_read_port #(
   parameter int DATA_W   = 24,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_entry,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] sel;

   // Zero-register forcing is applied last so it wins over the bypass path.
   always_comb begin
      sel = rd_entry;
      if (BYPASS != 0 && wr_en && wr_addr == rd_addr)
         sel = wr_data;
      if (ZERO_REG != 0 && rd_addr == '0)
         sel = '0;
   end

   // Output register: loads only on an accepted read, otherwise holds.
   always_ff @(posedge clk) begin
      if (!rst_n)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= sel;
   end

endmodule

module param_register_file #(
   parameter int DATA_W   = 24,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] read_reg_1,
   input  logic [ADDR_W-1:0] read_reg_2,
   output logic [DATA_W-1:0] data_reg_1,
   output logic [DATA_W-1:0] data_reg_2,
   output logic              read_valid,
   output logic              init_busy
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int NUM_RD = 2;

   typedef enum logic {INIT, READY} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;   // sweep pointer, terminal-compared at DEPTH-1
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              rd_go;
   logic              wr_go;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_entry;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

   assign rd_addr[0] = read_reg_1;
   assign rd_addr[1] = read_reg_2;
   assign data_reg_1 = rd_data[0];
   assign data_reg_2 = rd_data[1];

   // State and sweep pointer; reset restarts the sweep from entry 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and array write port: the sweep owns the write port in INIT,
   // requests own it in READY (writes to entry 0 dropped with ZERO_REG).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mem_we    = 1'b0;
      mem_waddr = write_reg;
      mem_wdata = write_data;
      init_busy = 1'b0;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      case (state)
         INIT: begin
            init_busy = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = '0;
            cnt_nxt   = cnt + ADDR_W'(1);
            if (cnt == {ADDR_W{1'b1}})
               state_nxt = READY;
         end
         READY: begin
            rd_go  = read_enable;
            wr_go  = write_enable;
            mem_we = write_enable && !(ZERO_REG != 0 && write_reg == '0);
         end
         default: state_nxt = INIT;
      endcase
   end

   // Storage array; no reset, the sweep establishes the zero contents.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   // read_valid marks the cycle after an accepted read.
   always_ff @(posedge clk) begin
      if (!rst_n)
         read_valid <= 1'b0;
      else
         read_valid <= rd_go;
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      assign rd_entry[g] = mem[rd_addr[g]];

      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .rd_en    (rd_go),
         .rd_addr  (rd_addr[g]),
         .rd_entry (rd_entry[g]),
         .wr_en    (wr_go),
         .wr_addr  (write_reg),
         .wr_data  (write_data),
         .rd_data  (rd_data[g])
      );
   end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three instances (defaults with bypass; no
// bypass with zero register; 32-bit x 8-entry). Shared stimulus drives the two
// 24-bit instances; expected read data comes from a hand-derived vector table
// and is queued at issue, popped when read_valid appears.
module tb_param_register_file;

   logic        clk, rst_n;
   logic        we, re;
   logic [4:0]  wa, r1, r2;
   logic [23:0] wd;
   logic [23:0] d1_b, d2_b, d1_n, d2_n;
   logic        rv_b, busy_b, rv_n, busy_n;
   logic        s_we, s_re;
   logic [2:0]  s_wa, s_r1, s_r2;
   logic [31:0] s_wd, s_d1, s_d2;
   logic        s_rv, s_busy;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [23:0] wd;
      logic        re;
      logic [4:0]  r1, r2;
      logic [23:0] e1_b, e2_b, e1_n, e2_n;
   } vec_t;

   typedef struct {
      logic [23:0] d1_b, d2_b, d1_n, d2_n;
   } exp_t;

   vec_t tbl[12];
   exp_t sb[$];
   exp_t hold;

   param_register_file #(.DATA_W(24), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) u_def (
      .clk(clk), .rst_n(rst_n), .write_enable(we), .write_reg(wa), .write_data(wd),
      .read_enable(re), .read_reg_1(r1), .read_reg_2(r2),
      .data_reg_1(d1_b), .data_reg_2(d2_b), .read_valid(rv_b), .init_busy(busy_b));

   param_register_file #(.DATA_W(24), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
      .clk(clk), .rst_n(rst_n), .write_enable(we), .write_reg(wa), .write_data(wd),
      .read_enable(re), .read_reg_1(r1), .read_reg_2(r2),
      .data_reg_1(d1_n), .data_reg_2(d2_n), .read_valid(rv_n), .init_busy(busy_n));

   param_register_file #(.DATA_W(32), .ADDR_W(3)) u_small (
      .clk(clk), .rst_n(rst_n), .write_enable(s_we), .write_reg(s_wa), .write_data(s_wd),
      .read_enable(s_re), .read_reg_1(s_r1), .read_reg_2(s_r2),
      .data_reg_1(s_d1), .data_reg_2(s_d2), .read_valid(s_rv), .init_busy(s_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp_v);
      end
   endtask

   function automatic vec_t v(input logic we_i, input logic [4:0] wa_i, input logic [23:0] wd_i,
                              input logic re_i, input logic [4:0] r1_i, input logic [4:0] r2_i,
                              input logic [23:0] b1, input logic [23:0] b2,
                              input logic [23:0] n1, input logic [23:0] n2);
      vec_t r;
      r.we = we_i; r.wa = wa_i; r.wd = wd_i; r.re = re_i; r.r1 = r1_i; r.r2 = r2_i;
      r.e1_b = b1; r.e2_b = b2; r.e1_n = n1; r.e2_n = n2;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One READY-state cycle on the shared 24-bit stimulus.
   task automatic cyc(input vec_t t);
      exp_t e;
      we = t.we; wa = t.wa; wd = t.wd; re = t.re; r1 = t.r1; r2 = t.r2;
      if (t.re) begin
         e.d1_b = t.e1_b; e.d2_b = t.e2_b; e.d1_n = t.e1_n; e.d2_n = t.e2_n;
         sb.push_back(e);
      end
      tick();
      we = 1'b0; re = 1'b0;
      check("init_busy", busy_b, 0);
      check("init_busy_nb", busy_n, 0);
      check("read_valid", rv_b, t.re);
      check("read_valid_nb", rv_n, t.re);
      if (rv_b) begin
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: read_valid with no pending read, got 1, want 0");
         end else begin
            hold = sb.pop_front();
         end
      end
      check("data_reg_1", d1_b, hold.d1_b);
      check("data_reg_2", d2_b, hold.d2_b);
      check("data_reg_1_nb", d1_n, hold.d1_n);
      check("data_reg_2_nb", d2_n, hold.d2_n);
   endtask

   // Holds rst_n low for n edges, then checks the reset-state outputs.
   task automatic do_reset(input int n);
      rst_n = 1'b0; we = 1'b0; re = 1'b0; s_we = 1'b0; s_re = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      hold = '{default: '0};
      check("rst_init_busy", busy_b, 1);
      check("rst_init_busy_small", s_busy, 1);
      check("rst_read_valid", rv_b, 0);
      check("rst_data_reg_1", d1_b, 0);
      check("rst_data_reg_2_nb", d2_n, 0);
      check("rst_data_reg_1_small", s_d1, 0);
   endtask

   // Counts samples with init_busy high, starting at the last reset edge.
   task automatic count_busy();
      int cb, cs;
      cb = 0; cs = 0;
      for (int k = 0; k < 100; k++) begin
         if (busy_b) cb++;
         if (s_busy) cs++;
         if (!busy_b && !s_busy) break;
         tick();
      end
      check("init_cycles", cb, 32);
      check("init_cycles_small", cs, 8);
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; re = 1'b0; wa = '0; wd = '0; r1 = '0; r2 = '0;
      s_we = 1'b0; s_re = 1'b0; s_wa = '0; s_wd = '0; s_r1 = '0; s_r2 = '0;
      hold = '{default: '0};

      //            we wa     wd           re r1     r2     def e1       def e2       nb e1        nb e2
      tbl[0]  = v(1, 5'd7,  24'hABCDEF, 0, 5'd0,  5'd0,  24'h0,       24'h0,       24'h0,       24'h0);
      tbl[1]  = v(0, 5'd0,  24'h0,      1, 5'd7,  5'd8,  24'hABCDEF,  24'h0,       24'hABCDEF,  24'h0);
      tbl[2]  = v(0, 5'd0,  24'h0,      0, 5'd0,  5'd0,  24'h0,       24'h0,       24'h0,       24'h0);
      tbl[3]  = v(1, 5'd3,  24'h111111, 0, 5'd0,  5'd0,  24'h0,       24'h0,       24'h0,       24'h0);
      tbl[4]  = v(1, 5'd3,  24'h123456, 1, 5'd3,  5'd3,  24'h123456,  24'h123456,  24'h111111,  24'h111111);
      tbl[5]  = v(0, 5'd0,  24'h0,      1, 5'd3,  5'd7,  24'h123456,  24'hABCDEF,  24'h123456,  24'hABCDEF);
      tbl[6]  = v(1, 5'd0,  24'hFFFFFF, 1, 5'd0,  5'd0,  24'hFFFFFF,  24'hFFFFFF,  24'h0,       24'h0);
      tbl[7]  = v(0, 5'd0,  24'h0,      1, 5'd0,  5'd3,  24'hFFFFFF,  24'h123456,  24'h0,       24'h123456);
      tbl[8]  = v(1, 5'd31, 24'hA5A5A5, 1, 5'd31, 5'd30, 24'hA5A5A5,  24'h0,       24'h0,       24'h0);
      tbl[9]  = v(1, 5'd30, 24'h5A5A5A, 1, 5'd31, 5'd30, 24'hA5A5A5,  24'h5A5A5A,  24'hA5A5A5,  24'h0);
      tbl[10] = v(0, 5'd0,  24'h0,      0, 5'd0,  5'd0,  24'h0,       24'h0,       24'h0,       24'h0);
      tbl[11] = v(1, 5'd8,  24'h000001, 1, 5'd8,  5'd31, 24'h000001,  24'hA5A5A5,  24'h0,       24'hA5A5A5);

      // Reset and clearing sweep, then every entry reads zero.
      do_reset(2);
      count_busy();
      for (int a = 0; a < 32; a++)
         cyc(v(0, 5'd0, 24'h0, 1, 5'(a), 5'(31 - a), 24'h0, 24'h0, 24'h0, 24'h0));

      // Main vector table.
      for (int i = 0; i < 12; i++)
         cyc(tbl[i]);

      // 32-bit x 8-entry instance: write then read back.
      s_we = 1'b1; s_wa = 3'd7; s_wd = 32'hDEADBEEF;
      tick();
      s_we = 1'b0; s_re = 1'b1; s_r1 = 3'd7; s_r2 = 3'd0;
      tick();
      s_re = 1'b0;
      check("small_read_valid", s_rv, 1);
      check("small_data_reg_1", s_d1, 32'hDEADBEEF);
      check("small_data_reg_2", s_d2, 32'h0);
      tick();
      check("small_read_valid_drop", s_rv, 0);
      check("small_data_hold", s_d1, 32'hDEADBEEF);

      // Requests during the sweep are ignored; mid-sweep reset restarts it.
      do_reset(1);
      repeat (4) tick();
      we = 1'b1; wa = 5'd5; wd = 24'h000055; re = 1'b1; r1 = 5'd5; r2 = 5'd5;
      tick();
      we = 1'b0; re = 1'b0;
      check("init_read_valid", rv_b, 0);
      check("init_read_valid_nb", rv_n, 0);
      check("init_data_reg_1", d1_b, 0);
      check("init_busy_mid", busy_b, 1);
      repeat (4) tick();
      do_reset(1);
      count_busy();
      cyc(v(0, 5'd0, 24'h0, 1, 5'd5, 5'd7, 24'h0, 24'h0, 24'h0, 24'h0));
      cyc(v(0, 5'd0, 24'h0, 1, 5'd31, 5'd3, 24'h0, 24'h0, 24'h0, 24'h0));

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
